// File: rtl/md_step_accumulator.sv
// md_step_accumulator: radix-4 multiply / non-restoring divide step accumulator driven by external digit-select logic.
module md_step_accumulator #(
  parameter int WIDTH = 26,
  parameter int CNTW  = 5
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               START,
  input  logic               MODE,
  input  logic               STEP,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               SG1,
  input  logic               SG2,
  input  logic               TFD,
  input  logic               ESD,
  output logic               BUSY,
  output logic               DONE,
  output logic               RSGN,
  output logic [2*WIDTH-1:0] PROD,
  output logic               DIVZ,
  output logic               DERR
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  localparam logic [CNTW-1:0] MUL_LAST = CNTW'(WIDTH/2 - 1);
  localparam logic [CNTW-1:0] DIV_LAST = CNTW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               rtop_q, rtop_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               divz_q, divz_d, derr_q, derr_d;
  logic [WIDTH+1:0]   m_hi, m_a, m_prod, m_sum;
  logic [WIDTH:0]     d_r, d_sum, f_sum;
  logic               opa_zero;
  assign opa_zero = (OPA == '0);
  // Multiply: upper half gains d*OPA in WIDTH+2 bits, then the whole accumulator shifts right by 2.
  always_comb begin
    m_hi   = {{2{acc_q[2*WIDTH-1]}}, acc_q[2*WIDTH-1:WIDTH]};
    m_a    = {{2{opa_q[WIDTH-1]}}, opa_q};
    m_prod = (TFD & ~ESD) ? {m_a[WIDTH:0], 1'b0} : (ESD & ~TFD) ? m_a : '0;
    m_sum  = SG1 ? m_hi - m_prod : m_hi + m_prod;
    d_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    d_sum  = SG2 ? d_r + {1'b0, opa_q} : d_r - {1'b0, opa_q};
    f_sum  = {rtop_q, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !START ? S_IDLE : !MODE ? S_MUL : opa_zero ? S_DONE : S_DIV;
      S_MUL:   state_d = (STEP && cnt_q == MUL_LAST) ? S_DONE : S_MUL;
      S_DIV:   state_d = (STEP && cnt_q == DIV_LAST) ? S_FIX : S_DIV;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    acc_d  = acc_q;
    rtop_d = rtop_q;
    opa_d  = opa_q;
    cnt_d  = cnt_q;
    divz_d = divz_q;
    derr_d = derr_q;
    if (state_q == S_IDLE && START) begin
      opa_d  = OPA;
      cnt_d  = '0;
      rtop_d = 1'b0;
      derr_d = 1'b0;
      divz_d = MODE & opa_zero;
      acc_d  = !MODE ? '0 : opa_zero ? {OPB, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, OPB};
    end else if (state_q == S_MUL && STEP) begin
      acc_d  = {m_sum, acc_q[WIDTH-1:2]};
      cnt_d  = cnt_q + 1'b1;
      derr_d = derr_q | (TFD & ESD);
    end else if (state_q == S_DIV && STEP) begin
      acc_d  = {d_sum[WIDTH-1:0], acc_q[WIDTH-2:0], ~d_sum[WIDTH]};
      rtop_d = d_sum[WIDTH];
      cnt_d  = cnt_q + 1'b1;
    end else if (state_q == S_FIX && rtop_q) begin
      acc_d  = {f_sum[WIDTH-1:0], acc_q[WIDTH-1:0]};
      rtop_d = f_sum[WIDTH];
    end
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      acc_q  <= '0;
      rtop_q <= 1'b0;
      opa_q  <= '0;
      cnt_q  <= '0;
      divz_q <= 1'b0;
      derr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      rtop_q <= rtop_d;
      opa_q  <= opa_d;
      cnt_q  <= cnt_d;
      divz_q <= divz_d;
      derr_q <= derr_d;
    end
  end
  always_comb begin
    BUSY = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    DONE = (state_q == S_DONE);
    RSGN = rtop_q;
    PROD = acc_q;
    DIVZ = divz_q;
    DERR = derr_q;
  end
endmodule
